// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, opcodes, bubble/halt words,
// fetch FSM encoding and the IF/ID bundle type.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_R_FORMAT = 6'd0;
    localparam logic [5:0] OP_J        = 6'd2;
    localparam logic [5:0] OP_BEQ      = 6'd4;
    localparam logic [5:0] OP_ADDIU    = 6'd9;
    localparam logic [5:0] OP_LW       = 6'd35;
    localparam logic [5:0] OP_SW       = 6'd43;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (stall) and clear-to-bubble (flush).
// Ports: clk, rst (sync, active-high), hold_i, flush_i, load_i,
//   instr_i/pc_plus4_i in; instr_o, pc_plus4_o, valid_o out.
module if_id_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;

    // Flush beats hold so a redirect kills a stalled instruction.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i && !hold_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, next-PC mux, RUN/HALTED FSM and IF/ID register.
// Ports: clk, rst (sync, active-high), stall, redirect, redirect_pc,
//   imem_rdata in; imem_addr, imem_en, ifid_instr, ifid_opcode,
//   ifid_pc_plus4, ifid_valid, halted, misalign_err, fetch_cnt, stall_cnt out.
// Macro IF_PERF_CNT_EN enables fetch/stall counters (else tied to zero).
module if_fetch_stage #(
    parameter int              XLEN       = mips_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [31:0]     NOP_INSTR  = mips_pkg::NOP_INSTR,
    parameter logic [31:0]     HALT_INSTR = mips_pkg::HALT_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_en,
    output logic [31:0]     ifid_instr,
    output logic [5:0]      ifid_opcode,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            ifid_valid,
    output logic            halted,
    output logic            misalign_err,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
);

    import mips_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic [0:0]      state_q, state_d;
    logic            mis_q, mis_d;

    logic running;
    logic do_redir;
    logic do_hold;
    logic do_halt;
    logic advance;
    logic flush;

    assign running  = (state_q == ST_RUN);
    assign pc_plus4 = pc_q + XLEN'(4);

    // Mutually exclusive edge actions in priority order.
    assign do_redir = redirect;
    assign do_hold  = stall && !redirect;
    assign do_halt  = running && !stall && !redirect
                   && (imem_rdata == HALT_INSTR);
    assign advance  = running && !stall && !redirect
                   && (imem_rdata != HALT_INSTR);

    // HALTED keeps feeding bubbles unless stalled.
    assign flush = do_redir || do_halt
                || (!running && !stall);

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        mis_d   = mis_q;
        unique case (1'b1)
            do_redir: begin
                pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
                state_d = ST_RUN;
                mis_d   = mis_q | (|redirect_pc[1:0]);
            end
            do_hold: ;
            do_halt: state_d = ST_HALTED;
            advance: pc_d = pc_plus4;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            mis_q   <= mis_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .hold_i     (do_hold),
        .flush_i    (flush),
        .load_i     (advance),
        .instr_i    (imem_rdata),
        .pc_plus4_i (pc_plus4),
        .instr_o    (ifid_instr),
        .pc_plus4_o (ifid_pc_plus4),
        .valid_o    (ifid_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign fetch_cnt_d = fetch_cnt_q + {31'd0, advance};
    assign stall_cnt_d = stall_cnt_q + {31'd0, do_hold};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 32'd0;
    assign stall_cnt = 32'd0;
`endif

    assign imem_addr    = pc_q;
    assign imem_en      = running && !stall && !rst;
    assign ifid_opcode  = opcode_of(ifid_instr);
    assign halted       = (state_q == ST_HALTED);
    assign misalign_err = mis_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage.
// Reference model predicts each edge; scoreboard compares after the edge.
module tb_if_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic        mis;
        logic        en;
        logic [5:0]  opc;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_opcode;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    logic        halt_on = 1'b0;
    logic [31:0] halt_addr = 32'd0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_instr = 32'd0;
    logic [31:0] m_pc4 = 32'd0;
    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_mis = 1'b0;
    logic [31:0] m_fcnt = 32'd0;
    logic [31:0] m_scnt = 32'd0;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_rdata    (imem_rdata),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .ifid_instr    (ifid_instr),
        .ifid_opcode   (ifid_opcode),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .misalign_err  (misalign_err),
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    // ADDIU-tagged word carrying the address, so every fetch is traceable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {6'd9, a[25:0]};
    endfunction

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        if (halt_on && a == halt_addr) return 32'hFFFF_FFFF;
        return mem_word(a);
    endfunction

    always_comb imem_rdata = mem_at(imem_addr);

    function automatic exp_t sample();
        exp_t a;
        a.pc     = imem_addr;
        a.instr  = ifid_instr;
        a.pc4    = ifid_pc_plus4;
        a.valid  = ifid_valid;
        a.halted = halted;
        a.mis    = misalign_err;
        a.en     = imem_en;
        a.opc    = ifid_opcode;
        a.fcnt   = fetch_cnt;
        a.scnt   = stall_cnt;
        return a;
    endfunction

    // Predict the effect of one edge with current inputs, push, then clock.
    task automatic cyc();
        exp_t e;
        logic [31:0] w;
        w = mem_at(m_pc);
        if (rst) begin
            m_pc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
            m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
            m_fcnt = 32'd0; m_scnt = 32'd0;
        end else if (redirect) begin
            m_pc = redirect_pc & ~32'h3;
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            m_halted = 1'b0;
            if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
        end else if (stall) begin
            m_scnt = m_scnt + 1;
        end else if (m_halted) begin
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (w == 32'hFFFF_FFFF) begin
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
            m_halted = 1'b1;
        end else begin
            m_instr = w;
            m_pc4 = m_pc + 32'd4;
            m_pc = m_pc + 32'd4;
            m_valid = 1'b1;
            m_fcnt = m_fcnt + 1;
        end
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
        e.valid = m_valid; e.halted = m_halted; e.mis = m_mis;
        e.en = !m_halted && !stall && !rst;
        e.opc = m_instr[31:26];
`ifdef IF_PERF_CNT_EN
        e.fcnt = m_fcnt; e.scnt = m_scnt;
`else
        e.fcnt = 32'd0; e.scnt = 32'd0;
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, a;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b0;
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %p expected %p", i, a, e);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e, a;
        for (int i = 0; i < 4; i++) begin
            stall = (i < 3);
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL stall[%0d]: got %p expected %p", i, a, e);
            end
        end
        checks++;
        if (imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL stall_resume_pc: got %h expected %h",
                     imem_addr, 32'h14);
        end
    endtask

    task automatic test_redirect();
        exp_t e, a;
        for (int i = 0; i < 4; i++) begin
            redirect = (i == 0) || (i == 2);
            stall = (i == 0);
            redirect_pc = (i == 0) ? 32'h40 : 32'h18;
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL redirect[%0d]: got %p expected %p", i, a, e);
            end
            if (i == 1) begin
                checks++;
                if (ifid_instr !== mem_word(32'h40) ||
                    ifid_pc_plus4 !== 32'h44) begin
                    errors++;
                    $display("FAIL redirect_target: got %h/%h expected %h/%h",
                             ifid_instr, ifid_pc_plus4,
                             mem_word(32'h40), 32'h44);
                end
            end
        end
        redirect = 1'b0; stall = 1'b0;
    endtask

    task automatic test_halt();
        exp_t e, a;
        halt_on = 1'b1; halt_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            redirect = (i == 6);
            redirect_pc = 32'h0;
            stall = (i == 4);
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL halt[%0d]: got %p expected %p", i, a, e);
            end
            if (i == 5) begin
                checks++;
                if (halted !== 1'b1 || imem_addr !== 32'h20) begin
                    errors++;
                    $display("FAIL halt_park: got halted=%b pc=%h expected 1/%h",
                             halted, imem_addr, 32'h20);
                end
            end
        end
        halt_on = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_misalign();
        exp_t e, a;
        for (int i = 0; i < 4; i++) begin
            redirect = (i == 0);
            redirect_pc = 32'h103;
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL misalign[%0d]: got %p expected %p", i, a, e);
            end
        end
        redirect = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        exp_t e, a;
        for (int i = 0; i < 8; i++) begin
            redirect = (i == 0);
            redirect_pc = 32'hFFFF_FFFC;
            stall = (i >= 3 && i <= 5);
            rst = (i == 5);
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL wrap_rst[%0d]: got %p expected %p", i, a, e);
            end
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e, a;
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(3) == 0);
            redirect = ($urandom_range(9) == 0);
            redirect_pc = $urandom_range(255);
            rst = ($urandom_range(49) == 0);
            cyc();
            e = sb.pop_front(); a = sample(); checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL random[%0d]: got %p expected %p", i, a, e);
            end
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_misalign();
        test_wrap_and_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0",
                     sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
